// File: rtl/axi4_rd_burst_fsm.sv
// AXI4 read-burst controller: accepts one AR at a time and streams arlen+1 beats
// from one of N_CH show-ahead output FIFOs, or an error burst without touching any FIFO.
module axi4_rd_burst_fsm #(
    parameter int unsigned ID_W     = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned N_CH     = 4,
    parameter int unsigned SEL_MODE = 0,
    parameter int unsigned SEL_LSB  = 12,
    parameter logic [2:0]  SIZE     = 3'd2,
    localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [7:0]        s_arlen,
    input  logic [2:0]        s_arsize,
    input  logic [1:0]        s_arburst,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [ID_W-1:0]   s_rid,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready,
    input  logic [N_CH-1:0]   fifo_empty,
    output logic              fifo_pop,
    output logic [CH_W-1:0]   fifo_pop_sel,
    output logic              busy,
    output logic [15:0]       burst_cnt
);

    localparam int unsigned N_PAD = 1 << CH_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] ERR  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [ID_W-1:0]  rid_q;
    logic [7:0]       beats_left;
    logic [CH_W-1:0]  sel_q;
    logic [1:0]       resp_q;
    logic [15:0]      cnt_q;

    logic [CH_W-1:0]  ch_c;
    logic [1:0]       resp_c;
    logic [N_PAD-1:0] empty_pad;
    logic             ar_fire;
    logic             r_fire;
    logic             unused_ok;

    // Channel decode from either the address field or the low ID bits
    generate
        if (SEL_MODE == 1) begin : g_sel_id
            assign ch_c = s_arid[CH_W-1:0];
        end else begin : g_sel_addr
            assign ch_c = s_araddr[SEL_LSB +: CH_W];
        end
    endgenerate

    assign unused_ok = ^s_araddr;

    // Decode error wins over slave error
    always_comb begin
        resp_c = RESP_OKAY;
        if (32'(ch_c) >= N_CH) begin
            resp_c = RESP_DECERR;
        end else if ((s_arburst != BURST_INCR) || (s_arsize != SIZE)) begin
            resp_c = RESP_SLVERR;
        end
    end

    // Unimplemented channel indices read as empty; only reachable in ERR, where they are ignored
    always_comb begin
        empty_pad             = '1;
        empty_pad[N_CH-1:0]   = fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rlast   = 1'b0;
        fifo_pop  = 1'b0;
        case (state)
            IDLE: begin
                s_arready = 1'b1;
                if (s_arvalid) begin
                    state_nxt = (resp_c == RESP_OKAY) ? DATA : ERR;
                end
            end
            DATA: begin
                s_rvalid = ~empty_pad[sel_q];
                s_rlast  = (beats_left == 8'd0);
                fifo_pop = s_rvalid & s_rready;
                if (s_rvalid && s_rready && s_rlast) begin
                    state_nxt = IDLE;
                end
            end
            ERR: begin
                s_rvalid = 1'b1;
                s_rlast  = (beats_left == 8'd0);
                if (s_rready && s_rlast) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Handshakes are blocked for the whole time reset is held
        if (reset) begin
            s_arready = 1'b0;
            s_rvalid  = 1'b0;
            s_rlast   = 1'b0;
            fifo_pop  = 1'b0;
        end
    end

    assign ar_fire = s_arvalid & s_arready;
    assign r_fire  = s_rvalid & s_rready;

    always_ff @(posedge clk) begin
        if (reset) begin
            rid_q      <= '0;
            beats_left <= 8'd0;
            sel_q      <= '0;
            resp_q     <= RESP_OKAY;
            cnt_q      <= 16'd0;
        end else if (ar_fire) begin
            rid_q      <= s_arid;
            beats_left <= s_arlen;
            sel_q      <= ch_c;
            resp_q     <= resp_c;
        end else if (r_fire) begin
            if (s_rlast) begin
                cnt_q <= cnt_q + 16'd1;
            end else begin
                beats_left <= beats_left - 8'd1;
            end
        end
    end

    assign s_rid        = rid_q;
    assign s_rresp      = resp_q;
    assign fifo_pop_sel = sel_q;
    assign busy         = (state != IDLE);
    assign burst_cnt    = cnt_q;

endmodule

// File: tb/tb_axi4_rd_burst_fsm.sv
// Bench for axi4_rd_burst_fsm: two instances (address-select N_CH=4, ID-select N_CH=3)
// driven from a request table plus reset, backpressure and long back-to-back sequences.
module tb_axi4_rd_burst_fsm;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        a_arvalid, b_arvalid;
    logic        rready;
    logic [3:0]  empty_a;
    logic [2:0]  empty_b;
    logic        dsel;

    logic        a_arready, a_rlast, a_rvalid, a_pop, a_busy;
    logic [3:0]  a_rid;
    logic [1:0]  a_rresp, a_sel;
    logic [15:0] a_cnt;
    logic        b_arready, b_rlast, b_rvalid, b_pop, b_busy;
    logic [3:0]  b_rid;
    logic [1:0]  b_rresp, b_sel;
    logic [15:0] b_cnt;

    axi4_rd_burst_fsm #(.N_CH(4), .SEL_MODE(0)) dut_a (
        .clk(clk), .reset(reset),
        .s_arid(arid), .s_araddr(araddr), .s_arlen(arlen), .s_arsize(arsize),
        .s_arburst(arburst), .s_arvalid(a_arvalid), .s_arready(a_arready),
        .s_rid(a_rid), .s_rresp(a_rresp), .s_rlast(a_rlast), .s_rvalid(a_rvalid),
        .s_rready(rready), .fifo_empty(empty_a), .fifo_pop(a_pop),
        .fifo_pop_sel(a_sel), .busy(a_busy), .burst_cnt(a_cnt)
    );

    axi4_rd_burst_fsm #(.N_CH(3), .SEL_MODE(1)) dut_b (
        .clk(clk), .reset(reset),
        .s_arid(arid), .s_araddr(araddr), .s_arlen(arlen), .s_arsize(arsize),
        .s_arburst(arburst), .s_arvalid(b_arvalid), .s_arready(b_arready),
        .s_rid(b_rid), .s_rresp(b_rresp), .s_rlast(b_rlast), .s_rvalid(b_rvalid),
        .s_rready(rready), .fifo_empty(empty_b), .fifo_pop(b_pop),
        .fifo_pop_sel(b_sel), .busy(b_busy), .burst_cnt(b_cnt)
    );

    logic        o_arready, o_rlast, o_rvalid, o_pop, o_busy;
    logic [3:0]  o_rid;
    logic [1:0]  o_rresp, o_sel;
    logic [15:0] o_cnt;
    assign o_arready = dsel ? b_arready : a_arready;
    assign o_rlast   = dsel ? b_rlast   : a_rlast;
    assign o_rvalid  = dsel ? b_rvalid  : a_rvalid;
    assign o_pop     = dsel ? b_pop     : a_pop;
    assign o_busy    = dsel ? b_busy    : a_busy;
    assign o_rid     = dsel ? b_rid     : a_rid;
    assign o_rresp   = dsel ? b_rresp   : a_rresp;
    assign o_sel     = dsel ? b_sel     : a_sel;
    assign o_cnt     = dsel ? b_cnt     : a_cnt;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
        logic       last;
        logic [1:0] sel;
    } beat_t;

    typedef struct packed {
        logic        d;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  exp_resp;
        logic [1:0]  exp_sel;
    } vec_t;

    beat_t       sb[$];
    vec_t        tbl[9];
    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] cnt_exp[2];
    logic [3:0]  last_rid[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic set_empty(input logic d, input logic [1:0] ch, input logic v);
        if (d) empty_b[ch] = v;
        else   empty_a[ch] = v;
    endtask

    // Issue one AR then drain the burst; expected beats go to the scoreboard at issue time
    task automatic run_burst(input logic d, input logic [3:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                             input logic [1:0] exp_resp, input logic [1:0] exp_sel,
                             input int empty_cycles, input logic toggle);
        logic  ok;
        int    len_beats;
        int    pops;
        int    beats;
        int    last_i;
        logic  done;
        logic  exp_rvalid;
        beat_t e;
        ok = (exp_resp == 2'b00);
        len_beats = int'(len) + 1;
        pops = 0; beats = 0; last_i = -1; done = 1'b0;
        @(negedge clk);
        dsel = d; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        if (d) b_arvalid = 1'b1; else a_arvalid = 1'b1;
        rready = 1'b1;
        #1;
        chk("arready_idle", 32'(o_arready), 32'd1);
        chk("busy_idle", 32'(o_busy), 32'd0);
        chk("rvalid_idle", 32'(o_rvalid), 32'd0);
        chk("burst_cnt", 32'(o_cnt), 32'(cnt_exp[d]));
        chk("rid_hold", 32'(o_rid), 32'(last_rid[d]));
        for (int k = 0; k < len_beats; k++) sb.push_back('{id, exp_resp, (k == len_beats - 1), exp_sel});
        for (int i = 1; (i <= len_beats * 2 + empty_cycles + 8) && !done; i++) begin
            @(negedge clk);
            a_arvalid = 1'b0; b_arvalid = 1'b0;
            if (empty_cycles > 0) set_empty(d, exp_sel, (i <= empty_cycles));
            rready = toggle ? (i % 2 == 1) : 1'b1;
            #1;
            exp_rvalid = ok ? (i > empty_cycles) : 1'b1;
            chk("rvalid", 32'(o_rvalid), 32'(exp_rvalid));
            chk("arready_busy", 32'(o_arready), 32'd0);
            chk("busy", 32'(o_busy), 32'd1);
            chk("fifo_pop", 32'(o_pop), 32'(ok & exp_rvalid & rready));
            if (o_pop) pops++;
            if (o_rvalid && rready) begin
                beats++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rid", 32'(o_rid), 32'(e.id));
                    chk("rresp", 32'(o_rresp), 32'(e.resp));
                    chk("rlast", 32'(o_rlast), 32'(e.last));
                    chk("pop_sel", 32'(o_sel), 32'(e.sel));
                end
                if (o_rlast) begin
                    done = 1'b1;
                    last_i = i;
                end
            end
        end
        if (!done) chk("burst_timeout", 32'd0, 32'd1);
        chk("beats", 32'(beats), 32'(len_beats));
        chk("pops", 32'(pops), ok ? 32'(len_beats) : 32'd0);
        if (!toggle) chk("last_cycle", 32'(last_i), 32'(empty_cycles + len_beats));
        cnt_exp[d] = cnt_exp[d] + 16'd1;
        last_rid[d] = id;
    endtask

    initial begin
        tbl[0] = '{1'b0, 4'h5, 32'h0000_2000, 8'd3, 3'd2, 2'b01, 2'b00, 2'd2};
        tbl[1] = '{1'b0, 4'h9, 32'h0000_3000, 8'd1, 3'd2, 2'b10, 2'b10, 2'd3};
        tbl[2] = '{1'b0, 4'h1, 32'h0000_0000, 8'd2, 3'd3, 2'b01, 2'b10, 2'd0};
        tbl[3] = '{1'b0, 4'hA, 32'h0000_1000, 8'd0, 3'd2, 2'b00, 2'b10, 2'd1};
        tbl[4] = '{1'b1, 4'h3, 32'h0000_0000, 8'd2, 3'd2, 2'b01, 2'b11, 2'd3};
        tbl[5] = '{1'b1, 4'hE, 32'h0000_0000, 8'd0, 3'd2, 2'b01, 2'b00, 2'd2};
        tbl[6] = '{1'b1, 4'h7, 32'h0000_0000, 8'd1, 3'd1, 2'b10, 2'b11, 2'd3};
        tbl[7] = '{1'b1, 4'h4, 32'h0000_0000, 8'd4, 3'd2, 2'b01, 2'b00, 2'd0};
        tbl[8] = '{1'b0, 4'h2, 32'hFFFF_1000, 8'd5, 3'd2, 2'b01, 2'b00, 2'd1};

        cnt_exp[0] = 16'd0; cnt_exp[1] = 16'd0;
        last_rid[0] = 4'd0; last_rid[1] = 4'd0;
        reset = 1'b1; dsel = 1'b0;
        arid = 4'd0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'd0;
        a_arvalid = 1'b0; b_arvalid = 1'b0; rready = 1'b1;
        empty_a = 4'd0; empty_b = 3'd0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_arready", 32'(o_arready), 32'd0);
        chk("rst_rvalid", 32'(o_rvalid), 32'd0);
        chk("rst_pop", 32'(o_pop), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_arready", 32'(o_arready), 32'd1);
        chk("post_rst_busy", 32'(o_busy), 32'd0);
        chk("post_rst_cnt", 32'(o_cnt), 32'd0);
        chk("post_rst_rid", 32'(o_rid), 32'd0);
        chk("post_rst_rresp", 32'(o_rresp), 32'd0);
        chk("post_rst_sel", 32'(o_sel), 32'd0);

        foreach (tbl[n])
            run_burst(tbl[n].d, tbl[n].id, tbl[n].addr, tbl[n].len, tbl[n].size, tbl[n].burst,
                      tbl[n].exp_resp, tbl[n].exp_sel, 0, 1'b0);

        // Channel 1 empty for three cycles, rready toggling 1,0,1
        run_burst(1'b0, 4'h6, 32'h0000_1000, 8'd2, 3'd2, 2'b01, 2'b00, 2'd1, 3, 1'b1);

        // Reset during beat 2 of an 8-beat burst
        @(negedge clk);
        dsel = 1'b0; arid = 4'h3; araddr = 32'h0000_2000; arlen = 8'd7;
        arsize = 3'd2; arburst = 2'b01; a_arvalid = 1'b1; rready = 1'b1;
        #1;
        chk("mid_arready", 32'(o_arready), 32'd1);
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            a_arvalid = 1'b0;
            #1;
            chk("mid_rvalid", 32'(o_rvalid), 32'd1);
            chk("mid_pop", 32'(o_pop), 32'd1);
            chk("mid_rid", 32'(o_rid), 32'h3);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_arready", 32'(o_arready), 32'd0);
        chk("mid_rst_rvalid", 32'(o_rvalid), 32'd0);
        chk("mid_rst_pop", 32'(o_pop), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("after_rst_rvalid", 32'(o_rvalid), 32'd0);
        chk("after_rst_pop", 32'(o_pop), 32'd0);
        chk("after_rst_arready", 32'(o_arready), 32'd1);
        chk("after_rst_busy", 32'(o_busy), 32'd0);
        chk("after_rst_cnt_a", 32'(o_cnt), 32'd0);
        chk("after_rst_cnt_b", 32'(b_cnt), 32'd0);
        cnt_exp[0] = 16'd0; cnt_exp[1] = 16'd0;
        last_rid[0] = 4'd0; last_rid[1] = 4'd0;

        // Two maximum-length bursts back to back
        run_burst(1'b0, 4'hB, 32'h0000_0000, 8'd255, 3'd2, 2'b01, 2'b00, 2'd0, 0, 1'b0);
        run_burst(1'b0, 4'hC, 32'h0000_3000, 8'd255, 3'd2, 2'b01, 2'b00, 2'd3, 0, 1'b0);

        @(negedge clk);
        dsel = 1'b0;
        #1;
        chk("final_cnt", 32'(o_cnt), 32'd2);
        chk("final_arready", 32'(o_arready), 32'd1);
        chk("final_rid_hold", 32'(o_rid), 32'hC);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
